// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: trap kinds, sequencer states and mcause/mtvec encodings shared with the CSR file
package trap_ctrl_pkg;
    typedef enum logic [1:0] {EXC, MRET, IRQ} trap_kind_t;
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} trap_state_t;
    localparam logic [63:0] MCAUSE_INTERRUPT_MASK = 64'h8000_0000_0000_0000;
    localparam logic [1:0] MTVEC_MODE_DIRECT = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;
endpackage

// File: rtl/trap_target_calc.sv
// trap_target_calc: trap vector target from a tvec register, direct or vectored by interrupt code
module trap_target_calc import trap_ctrl_pkg::*; #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] tvec,
    input  logic            is_irq,
    input  logic [5:0]      code,
    output logic [XLEN-1:0] target
);
    logic [XLEN-1:0] base;
    // only vectored mode offsets, and only for interrupts; reserved modes behave as direct
    always_comb begin
        base = {tvec[XLEN-1:2], 2'b00};
        target = (tvec[1:0] == MTVEC_MODE_VECTORED && is_irq) ? base + XLEN'({code, 2'b00}) : base;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: arbitrates exceptions, mret and interrupts, drains the data bus, strobes the CSR file, then flushes and redirects fetch
module trap_ctrl import trap_ctrl_pkg::*; #(
    parameter int XLEN = 64,
    parameter int DRAIN_MAX = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_valid,
    input  logic            irq_pending,
    input  logic [XLEN-1:0] irq_cause,
    input  logic [XLEN-1:0] irq_pc,
    input  logic            mem_busy,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            stall,
    output logic            csr_trap_we,
    output logic [XLEN-1:0] csr_trap_epc,
    output logic [XLEN-1:0] csr_trap_cause,
    output logic            csr_mret_we,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            drain_timeout
);
    localparam logic [XLEN-1:0] IRQ_BIT = MCAUSE_INTERRUPT_MASK[63 -: XLEN];

    trap_state_t     state, state_n;
    trap_kind_t      kind;
    logic [CNT_W-1:0] cnt;
    logic            cnt_last;
    logic [XLEN-1:0] target;

    assign cnt_last = cnt == CNT_W'(DRAIN_MAX - 1);

    trap_target_calc #(.XLEN(XLEN)) u_target (
        .tvec  (mtvec),
        .is_irq(kind == IRQ),
        .code  (csr_trap_cause[5:0]),
        .target(target)
    );

    // state register, event capture in IDLE and saturating drain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            kind <= EXC;
            cnt <= '0;
            csr_trap_epc <= '0;
            csr_trap_cause <= '0;
            drain_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                cnt <= '0;
                if (exc_valid) begin
                    kind <= EXC;
                    csr_trap_epc <= exc_pc;
                    csr_trap_cause <= exc_cause;
                end else if (mret_valid) begin
                    kind <= MRET;
                end else if (irq_pending) begin
                    kind <= IRQ;
                    csr_trap_epc <= irq_pc;
                    csr_trap_cause <= irq_cause | IRQ_BIT;
                end
            end
            if (state == DRAIN && mem_busy) begin
                if (cnt_last) drain_timeout <= 1'b1;
                else cnt <= cnt + 1'b1;
            end
        end
    end

    // next state and per-state strobes
    always_comb begin
        state_n = state;
        stall = state != IDLE;
        csr_trap_we = 1'b0;
        csr_mret_we = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        case (state)
            IDLE: state_n = (exc_valid || mret_valid || irq_pending) ? DRAIN : IDLE;
            DRAIN: state_n = (!mem_busy || cnt_last) ? COMMIT : DRAIN;
            COMMIT: begin
                csr_trap_we = kind != MRET;
                csr_mret_we = kind == MRET;
                state_n = REDIRECT;
            end
            default: begin
                flush = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc = kind == MRET ? mepc : target;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table plus reset-in-drain sequence for trap_ctrl
module tb_trap_ctrl;
    logic        clk = 0;
    logic        reset = 1;
    logic        exc_valid = 0, mret_valid = 0, irq_pending = 0, mem_busy = 0;
    logic [63:0] exc_cause = 0, exc_pc = 0, irq_cause = 0, irq_pc = 0, mtvec = 0, mepc = 0;
    logic        stall, csr_trap_we, csr_mret_we, flush, redirect_valid, drain_timeout;
    logic [63:0] csr_trap_epc, csr_trap_cause, redirect_pc;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .mret_valid(mret_valid), .irq_pending(irq_pending), .irq_cause(irq_cause), .irq_pc(irq_pc),
        .mem_busy(mem_busy), .mtvec(mtvec), .mepc(mepc),
        .stall(stall), .csr_trap_we(csr_trap_we), .csr_trap_epc(csr_trap_epc),
        .csr_trap_cause(csr_trap_cause), .csr_mret_we(csr_mret_we), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .drain_timeout(drain_timeout)
    );

    typedef struct {
        logic        ev_exc, ev_mret, ev_irq;
        logic [63:0] ecause, epc_in, icause, ipc, tvec, mepc_in;
        int          busy, at;
        logic        is_mret;
        logic [63:0] cause, epc, pc;
        logic        tmo;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic m, input logic i,
                                input logic [63:0] ec, input logic [63:0] ep, input logic [63:0] ic,
                                input logic [63:0] ip, input logic [63:0] tv, input logic [63:0] me,
                                input int busy, input int at, input logic [63:0] cause,
                                input logic [63:0] epc, input logic [63:0] pc, input logic tmo);
        vec_t v;
        v.ev_exc = e; v.ev_mret = m; v.ev_irq = i;
        v.ecause = ec; v.epc_in = ep; v.icause = ic; v.ipc = ip; v.tvec = tv; v.mepc_in = me;
        v.busy = busy; v.at = at; v.is_mret = m && !e;
        v.cause = cause; v.epc = epc; v.pc = pc; v.tmo = tmo;
        return v;
    endfunction

    task automatic run_vec(input int n);
        vec_t v = vt[n];
        int got = 0;
        logic t_we = 0, m_we = 0;
        logic [63:0] s_epc = 0, s_cause = 0;
        @(negedge clk);
        chk($sformatf("v%0d idle stall", n), 64'(stall), 64'd0);
        exc_valid = v.ev_exc; mret_valid = v.ev_mret; irq_pending = v.ev_irq;
        exc_cause = v.ecause; exc_pc = v.epc_in; irq_cause = v.icause; irq_pc = v.ipc;
        mtvec = v.tvec; mepc = v.mepc_in;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (j == 1) begin
                exc_valid = 0; mret_valid = 0; irq_pending = 0;
                chk($sformatf("v%0d drain stall", n), 64'(stall), 64'd1);
            end
            if (csr_trap_we || csr_mret_we) begin
                got = j; t_we = csr_trap_we; m_we = csr_mret_we;
                s_epc = csr_trap_epc; s_cause = csr_trap_cause;
                break;
            end
            mem_busy = j <= v.busy;
        end
        mem_busy = 0;
        chk($sformatf("v%0d strobe cycle", n), 64'(got), 64'(v.at));
        chk($sformatf("v%0d trap_we", n), 64'(t_we), 64'(!v.is_mret));
        chk($sformatf("v%0d mret_we", n), 64'(m_we), 64'(v.is_mret));
        if (!v.is_mret) begin
            chk($sformatf("v%0d cause", n), s_cause, v.cause);
            chk($sformatf("v%0d epc", n), s_epc, v.epc);
        end
        @(negedge clk);
        chk($sformatf("v%0d redirect_valid", n), 64'(redirect_valid), 64'd1);
        chk($sformatf("v%0d flush", n), 64'(flush), 64'd1);
        chk($sformatf("v%0d redirect_pc", n), redirect_pc, v.pc);
        chk($sformatf("v%0d strobes off", n), 64'(csr_trap_we | csr_mret_we), 64'd0);
        chk($sformatf("v%0d timeout", n), 64'(drain_timeout), 64'(v.tmo));
    endtask

    initial begin
        vt[0] = mk(1, 0, 0, 2, 64'h80000010, 0, 0, 64'h80001000, 64'hDEAD0000, 0, 2, 2, 64'h80000010, 64'h80001000, 0);
        vt[1] = mk(0, 0, 1, 0, 0, 7, 64'h80000044, 64'h80001001, 64'hDEAD0000, 0, 2, 64'h8000000000000007, 64'h80000044, 64'h8000101C, 0);
        vt[2] = mk(1, 1, 1, 5, 64'h100, 3, 64'h200, 64'h80001001, 64'hDEAD0000, 0, 2, 5, 64'h100, 64'h80001000, 0);
        vt[3] = mk(0, 1, 0, 0, 0, 0, 0, 64'h80001000, 64'h80000200, 5, 7, 0, 0, 64'h80000200, 0);
        vt[4] = mk(1, 0, 0, 11, 64'h44, 0, 0, 64'h2003, 64'hDEAD0000, 1, 3, 11, 64'h44, 64'h2000, 0);
        vt[5] = mk(0, 0, 1, 0, 0, 63, 64'h1234, 64'hFFFFFFFFFFFFFFFD, 64'hDEAD0000, 0, 2, 64'h800000000000003F, 64'h1234, 64'hF8, 0);
        vt[6] = mk(0, 0, 1, 0, 0, 64'h47, 64'h88, 64'h1001, 64'hDEAD0000, 0, 2, 64'h8000000000000047, 64'h88, 64'h101C, 0);
        vt[7] = mk(0, 1, 0, 0, 0, 0, 0, 64'h1000, 64'h4000, 63, 65, 0, 0, 64'h4000, 0);
        vt[8] = mk(1, 0, 0, 1, 64'h10, 0, 0, 64'h3000, 64'hDEAD0000, 200, 65, 1, 64'h10, 64'h3000, 1);
        vt[9] = mk(1, 0, 0, 4, 64'h20, 0, 0, 64'h3002, 64'hDEAD0000, 0, 2, 4, 64'h20, 64'h3000, 1);
        repeat (2) @(negedge clk);
        reset = 0;
        chk("reset stall", 64'(stall), 0);
        chk("reset strobes", 64'(csr_trap_we | csr_mret_we | flush | redirect_valid), 0);
        chk("reset redirect_pc", redirect_pc, 0);
        chk("reset epc", csr_trap_epc, 0);
        chk("reset cause", csr_trap_cause, 0);
        chk("reset timeout", 64'(drain_timeout), 0);
        for (int n = 0; n < 10; n++) run_vec(n);
        @(negedge clk);
        exc_valid = 1; exc_cause = 9; exc_pc = 64'h500; mtvec = 64'h6000;
        @(negedge clk);
        exc_valid = 0; mem_busy = 1;
        chk("rst seq drain stall", 64'(stall), 1);
        reset = 1;
        @(negedge clk);
        reset = 0; mem_busy = 0;
        chk("rst seq stall", 64'(stall), 0);
        chk("rst seq strobes", 64'(csr_trap_we | csr_mret_we | flush | redirect_valid), 0);
        chk("rst seq redirect_pc", redirect_pc, 0);
        chk("rst seq epc", csr_trap_epc, 0);
        chk("rst seq cause", csr_trap_cause, 0);
        chk("rst seq timeout", 64'(drain_timeout), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst seq quiet", 64'(stall | csr_trap_we | csr_mret_we | flush | redirect_valid), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
